// File: rtl/rsa_modexp_seq_if.sv
// Operand-load / result bus for rsa_modexp_seq.
// master: operand source and result consumer. slave: the exponentiation core.
interface rsa_modexp_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  ctrl_load;
  logic [DATA_WIDTH-1:0] ctrl_din;
  logic                  ctrl_abort;
  logic                  ctrl_busy;
  logic                  ctrl_done;
  logic                  ctrl_err;
  logic [DATA_WIDTH-1:0] ctrl_c;

  modport master (
    output ctrl_load, ctrl_din, ctrl_abort,
    input  ctrl_busy, ctrl_done, ctrl_err, ctrl_c
  );

  modport slave (
    input  ctrl_load, ctrl_din, ctrl_abort,
    output ctrl_busy, ctrl_done, ctrl_err, ctrl_c
  );
endinterface

// File: rtl/rsa_modexp_seq.sv
// Sequential modular exponentiation c = m^e mod n, right-to-left
// square-and-multiply over a shared bit-serial interleaved modular multiplier.
// Optional feature: define RSA_MODEXP_REDUCE_M_EN to accept m>=n and
// pre-reduce m with one extra multiplier pass; otherwise m>=n is an error.
module rsa_modexp_seq #(
  parameter int   DATA_WIDTH = 16,
  parameter logic LOAD       = 1'b0
) (
  input logic             ctrl_clk,
  input logic             ctrl_rst,
  rsa_modexp_seq_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [3:0] {
    S_LOAD_M,
    S_WAIT_M,
    S_LOAD_E,
    S_WAIT_E,
    S_LOAD_N,
    S_WAIT_N,
    S_CHECK,
`ifdef RSA_MODEXP_REDUCE_M_EN
    S_REDUCE,
`endif
    S_MUL,
    S_SQR,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [W-1:0]  m_q, e_q, n_q, x_q, c_q;
  logic [W+1:0]  acc;
  logic [CW-1:0] cnt;
  logic          busy_q, done_q, err_q;

  logic          ld_act;
  logic          computing;
  logic [W-1:0]  mul_a, mul_b, prod, e_shr;
  logic [W+1:0]  n_ext, acc_sum, acc_s1, acc_nxt;

  assign ld_act = (bus.ctrl_load == LOAD);
  assign n_ext  = {2'b00, n_q};
  assign e_shr  = e_q >> 1;
  assign prod   = acc_nxt[W-1:0];

  // Operand select and one interleaved step: r = 2r + a_i*b, then up to two -n
  always_comb begin
    mul_a     = m_q;
    mul_b     = m_q;
    computing = 1'b0;
    case (state)
      S_MUL: begin
        mul_a     = x_q;
        computing = 1'b1;
      end
      S_SQR: computing = 1'b1;
`ifdef RSA_MODEXP_REDUCE_M_EN
      S_REDUCE: begin
        mul_b     = {{(W-1){1'b0}}, 1'b1};
        computing = 1'b1;
      end
`endif
      default: ;
    endcase
    acc_sum = (acc << 1) + (mul_a[cnt] ? {2'b00, mul_b} : '0);
    acc_s1  = (acc_sum >= n_ext) ? acc_sum - n_ext : acc_sum;
    acc_nxt = (acc_s1  >= n_ext) ? acc_s1  - n_ext : acc_s1;
  end

  // Control FSM, operand/working registers and registered outputs
  always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      state  <= S_LOAD_M;
      m_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      x_q    <= '0;
      c_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // busy covers the done cycle and drops at the edge that ends it
      if (done_q) busy_q <= 1'b0;

      // shared multiplier step; the writeback happens in the case below
      if (computing && !bus.ctrl_abort) begin
        acc <= (cnt == '0) ? '0 : acc_nxt;
        cnt <= (cnt == '0) ? CW'(W-1) : cnt - 1'b1;
      end

      case (state)
        S_LOAD_M: if (ld_act && !busy_q) begin
          m_q   <= bus.ctrl_din;
          err_q <= 1'b0;
          state <= S_WAIT_M;
        end
        S_WAIT_M: if (!ld_act) state <= S_LOAD_E;
        S_LOAD_E: if (ld_act) begin
          e_q   <= bus.ctrl_din;
          state <= S_WAIT_E;
        end
        S_WAIT_E: if (!ld_act) state <= S_LOAD_N;
        S_LOAD_N: if (ld_act) begin
          n_q   <= bus.ctrl_din;
          state <= S_WAIT_N;
        end
        S_WAIT_N: if (!ld_act) begin
          busy_q <= 1'b1;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.ctrl_abort) begin
            busy_q <= 1'b0;
            state  <= S_LOAD_M;
          end else if (n_q == '0) begin
            state <= S_ERROR;
`ifndef RSA_MODEXP_REDUCE_M_EN
          end else if (m_q >= n_q) begin
            state <= S_ERROR;
`endif
          end else if (n_q == W'(1)) begin
            x_q   <= '0;
            state <= S_DONE;
          end else if (e_q == '0) begin
            x_q   <= W'(1);
            state <= S_DONE;
          end else begin
            x_q <= W'(1);
            acc <= '0;
            cnt <= CW'(W-1);
`ifdef RSA_MODEXP_REDUCE_M_EN
            state <= S_REDUCE;
`else
            state <= e_q[0] ? S_MUL : S_SQR;
`endif
          end
        end
`ifdef RSA_MODEXP_REDUCE_M_EN
        S_REDUCE: begin
          if (bus.ctrl_abort) begin
            busy_q <= 1'b0;
            state  <= S_LOAD_M;
          end else if (cnt == '0) begin
            m_q   <= prod;
            state <= e_q[0] ? S_MUL : S_SQR;
          end
        end
`endif
        S_MUL: begin
          if (bus.ctrl_abort) begin
            busy_q <= 1'b0;
            state  <= S_LOAD_M;
          end else if (cnt == '0) begin
            x_q   <= prod;
            state <= S_SQR;
          end
        end
        S_SQR: begin
          if (bus.ctrl_abort) begin
            busy_q <= 1'b0;
            state  <= S_LOAD_M;
          end else if (cnt == '0) begin
            // the LOOP decision is folded into the last squaring edge
            m_q <= prod;
            e_q <= e_shr;
            if (e_shr == '0)  state <= S_DONE;
            else if (e_shr[0]) state <= S_MUL;
            else               state <= S_SQR;
          end
        end
        S_DONE: begin
          c_q    <= x_q;
          err_q  <= 1'b0;
          done_q <= 1'b1;
          state  <= S_LOAD_M;
        end
        S_ERROR: begin
          c_q    <= '1;
          err_q  <= 1'b1;
          done_q <= 1'b1;
          state  <= S_LOAD_M;
        end
        default: state <= S_LOAD_M;
      endcase
    end
  end

  assign bus.ctrl_busy = busy_q;
  assign bus.ctrl_done = done_q;
  assign bus.ctrl_err  = err_q;
  assign bus.ctrl_c    = c_q;
endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Self-checking bench for rsa_modexp_seq: directed cases, abort/reset,
// back-to-back loads and random operands against an arithmetic model.
module tb_rsa_modexp_seq;
  localparam int   W  = 16;
  localparam logic LD = 1'b0;
`ifdef RSA_MODEXP_REDUCE_M_EN
  localparam int RED = 1;
`else
  localparam int RED = 0;
`endif

  logic ctrl_clk = 1'b0;
  logic ctrl_rst = 1'b1;

  rsa_modexp_seq_if #(.DATA_WIDTH(W)) bus ();

  rsa_modexp_seq #(.DATA_WIDTH(W), .LOAD(LD)) dut (
    .ctrl_clk (ctrl_clk),
    .ctrl_rst (ctrl_rst),
    .bus      (bus)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int           checks = 0;
  int           fails  = 0;
  logic [W-1:0] exp_c_last   = '0;
  logic         exp_err_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Result, error flag and done latency (edges after E0) from the rules
  function automatic void model(input longint m, input longint e, input longint n,
                                output logic err, output longint c, output int lat);
    longint b, x, t;
    int     k;
    lat = 2;
    err = 1'b0;
    if (n == 0 || (m >= n && RED == 0)) begin
      err = 1'b1;
      c   = (64'd1 << W) - 1;
      return;
    end
    if (n == 1) begin c = 0; return; end
    if (e == 0) begin c = 1; return; end
    b = m % n; x = 1; t = e; k = 0;
    while (t != 0) begin
      if (t[0]) x = (x * b) % n;
      b = (b * b) % n;
      t = t >> 1;
      k++;
    end
    c   = x;
    lat = 2 + W * (RED + k + $countones(e));
  endfunction

  task automatic load_op(input logic [W-1:0] v, input int hold, input bit is_m);
    @(negedge ctrl_clk);
    bus.ctrl_load = LD;
    bus.ctrl_din  = v;
    @(negedge ctrl_clk);
    if (is_m) chk("err_clr_on_m", bus.ctrl_err, 0);
    repeat (hold - 1) @(negedge ctrl_clk);
    bus.ctrl_load = ~LD;
  endtask

  task automatic load_all(input logic [W-1:0] m, e, n, input int hold);
    load_op(m, hold, 1'b1);
    load_op(e, hold, 1'b0);
    load_op(n, hold, 1'b0);
  endtask

  task automatic run_op(input logic [W-1:0] m, e, n, input int hold, input string tag);
    logic   xerr;
    longint xc;
    int     lat, k;
    model(m, e, n, xerr, xc, lat);
    load_all(m, e, n, hold);
    @(negedge ctrl_clk);
    chk({tag, "_busy_rise"}, bus.ctrl_busy, 1);
    k = 0;
    while (bus.ctrl_done !== 1'b1 && k < 3000) begin
      @(negedge ctrl_clk);
      k++;
    end
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_c"}, bus.ctrl_c, xc);
    chk({tag, "_err"}, bus.ctrl_err, xerr);
    chk({tag, "_busy_in_done"}, bus.ctrl_busy, 1);
    @(negedge ctrl_clk);
    chk({tag, "_done_1cyc"}, bus.ctrl_done, 0);
    chk({tag, "_busy_fall"}, bus.ctrl_busy, 0);
    exp_c_last   = xc[W-1:0];
    exp_err_last = xerr;
  endtask

  initial begin
    int dn;
    logic [W-1:0] rm, re, rn;
    bus.ctrl_load  = ~LD;
    bus.ctrl_din   = '0;
    bus.ctrl_abort = 1'b0;

    #12;
    chk("rst_busy", bus.ctrl_busy, 0);
    chk("rst_done", bus.ctrl_done, 0);
    chk("rst_err",  bus.ctrl_err,  0);
    chk("rst_c",    bus.ctrl_c,    0);
    @(negedge ctrl_clk);
    ctrl_rst = 1'b0;

    run_op(16'd4,   16'd13, 16'd497, 1, "baseline");
    run_op(16'd5,   16'd3,  16'd0,   1, "n_zero");
    run_op(16'd3,   16'd0,  16'd7,   1, "e_zero");
    run_op(16'd5,   16'd3,  16'd1,   1, "n_one_big_m");
    run_op(16'd0,   16'd3,  16'd1,   1, "n_one");
    run_op(16'd600, 16'd3,  16'd497, 1, "oversized_m");
    run_op(16'd496, 16'd65535, 16'd497, 1, "max_e");

    // abort during the first squaring pass; result and flag must stay put
    run_op(16'd9, 16'd5, 16'd101, 1, "pre_abort");
    load_all(16'd4, 16'd13, 16'd497, 1);
    @(negedge ctrl_clk);
    repeat (20) @(negedge ctrl_clk);
    bus.ctrl_abort = 1'b1;
    @(negedge ctrl_clk);
    bus.ctrl_abort = 1'b0;
    chk("abort_busy", bus.ctrl_busy, 0);
    chk("abort_done", bus.ctrl_done, 0);
    chk("abort_c",    bus.ctrl_c,    exp_c_last);
    chk("abort_err",  bus.ctrl_err,  exp_err_last);
    dn = 0;
    repeat (200) begin
      @(negedge ctrl_clk);
      if (bus.ctrl_done === 1'b1) dn++;
    end
    chk("abort_no_done", dn, 0);
    run_op(16'd2, 16'd10, 16'd1000, 1, "after_abort");

    // asynchronous reset in the middle of a multiply pass
    load_all(16'd4, 16'd13, 16'd497, 1);
    @(negedge ctrl_clk);
    repeat (5) @(negedge ctrl_clk);
    #2 ctrl_rst = 1'b1;
    #1;
    chk("arst_busy", bus.ctrl_busy, 0);
    chk("arst_done", bus.ctrl_done, 0);
    chk("arst_err",  bus.ctrl_err,  0);
    chk("arst_c",    bus.ctrl_c,    0);
    @(negedge ctrl_clk);
    ctrl_rst = 1'b0;
    exp_c_last   = '0;
    exp_err_last = 1'b0;
    run_op(16'd4, 16'd13, 16'd497, 1, "after_rst");

    // back-to-back with held strobes, starting from an error state
    run_op(16'd1, 16'd1, 16'd0, 3, "b2b_err");
    run_op(16'd123, 16'd45, 16'd1009, 3, "b2b_1");
    run_op(16'd2, 16'd10, 16'd1000, 3, "b2b_2");

    for (int i = 0; i < 8; i++) begin
      rn = 16'($urandom_range(2, 65535));
      rm = 16'($urandom % rn);
      if ($urandom_range(0, 3) == 0) rm = 16'($urandom_range(0, 65535));
      re = 16'($urandom_range(0, 65535));
      run_op(rm, re, rn, $urandom_range(1, 3), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
